// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: instruction-memory request/response,
// decode-side valid/ready with PC, redirect control and occupancy.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [LW-1:0]   level;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, level,
    input  imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, level,
    output imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch stage: sequential word fetches to a 1-cycle
// memory, buffered with their PCs in a DEPTH-entry FIFO toward decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master fq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] inflight_pc_reg;
  logic            inflight_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic [CW:0] credit_used;
  logic        req;
  logic        push;
  logic        pop;
  logic        unused_bits;

  // In-flight fetches reserve a slot, so a push can never find the FIFO full.
  assign credit_used = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign req         = !rst && !fq.redirect && (credit_used < (CW + 1)'(DEPTH));
  assign push        = inflight_reg && !fq.redirect && !rst;
  assign pop         = fq.inst_valid && fq.inst_ready;
  assign unused_bits = ^fq.redirect_pc[1:0];

  assign fq.imem_req   = req;
  assign fq.imem_addr  = fetch_pc_reg;
  assign fq.inst_valid = (count_reg != '0) && !fq.redirect && !rst;
  assign fq.inst       = inst_mem[rd_ptr_reg];
  assign fq.inst_pc    = pc_mem[rd_ptr_reg];
  assign fq.level      = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (fq.redirect) begin
      // Whatever returns next cycle belongs to the old path and is dropped.
      fetch_pc_reg <= {fq.redirect_pc[XLEN-1:2], 2'b00};
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= req;
      if (req) begin
        fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
        inflight_pc_reg <= fetch_pc_reg;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
      inst_mem[wr_ptr_reg] <= fq.imem_rdata;
    end
  end
endmodule
